// File: rtl/tetris_pkg.sv
// Shared Tetris types: shape codes, spawner FSM states and board geometry.
package tetris_pkg;

   typedef enum logic [2:0] {
      SHAPE_NONE = 3'd0,
      SHAPE_I    = 3'd1,
      SHAPE_O    = 3'd2,
      SHAPE_T    = 3'd3,
      SHAPE_S    = 3'd4,
      SHAPE_Z    = 3'd5,
      SHAPE_J    = 3'd6,
      SHAPE_L    = 3'd7
   } shape_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_WAIT   = 3'd2,
      ST_CHECK  = 3'd3,
      ST_ACTIVE = 3'd4,
      ST_OVER   = 3'd5
   } spawner_state_t;

   localparam int BOARD_W = 10;
   localparam int BOARD_H = 20;

   // Code 0 means "no piece"; every other 3-bit code is a real shape.
   function automatic logic shape_legal(input logic [2:0] code);
      return (code != 3'd0);
   endfunction

endpackage

// File: rtl/hold_slot.sv
// Hold slot for the spawner: remembers one shape and whether hold has
// already been used for the current piece. Only built with HOLD_PIECE_EN.
import tetris_pkg::*;

module hold_slot (
   input  logic   Clk,
   input  logic   Reset,
   input  logic   clear,
   input  logic   release_use,
   input  logic   hold_go,
   input  shape_t active_shape,
   output shape_t hold_shape,
   output logic   hold_used
);

   // Capture the active shape on an accepted hold; a lock re-arms hold.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         hold_shape <= SHAPE_NONE;
         hold_used  <= 1'b0;
      end else if (clear) begin
         hold_shape <= SHAPE_NONE;
         hold_used  <= 1'b0;
      end else if (hold_go) begin
         hold_shape <= active_shape;
         hold_used  <= 1'b1;
      end else if (release_use) begin
         hold_used  <= 1'b0;
      end
   end

endmodule

// File: rtl/piece_spawner.sv
// Piece spawner: requests shapes from the generator, places them at the
// spawn origin, detects spawn collisions (game over) and, when the
// HOLD_PIECE_EN macro is defined, supports a one-shot hold slot.
import tetris_pkg::*;

module piece_spawner #(
   parameter int SPAWN_X     = 4,
   parameter int SPAWN_Y     = 0,
   parameter int REQ_TIMEOUT = 31
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       start,
   input  logic       lock,
   input  logic       piece_valid,
   input  logic [2:0] piece_in,
   input  logic       occupied,
   input  logic       hold_req,
   output logic       piece_req,
   output logic [2:0] active_shape,
   output logic [3:0] spawn_x,
   output logic [4:0] spawn_y,
   output logic [1:0] rotation,
   output logic       spawn_pulse,
   output logic [2:0] hold_shape,
   output logic       game_over
);

   localparam int CNT_W = $clog2(REQ_TIMEOUT + 1);

   spawner_state_t   state;
   shape_t           cur_shape;
   shape_t           held;
   logic [CNT_W-1:0] wait_cnt;
   logic             hold_go;

   assign active_shape = cur_shape;
   assign hold_shape   = held;
   assign rotation     = 2'd0;

`ifdef HOLD_PIECE_EN
   logic hold_used;

   // Hold is accepted only in ACTIVE, once per piece, and loses to lock/start.
   assign hold_go = (state == ST_ACTIVE) && hold_req && !lock && !start && !hold_used;

   hold_slot u_hold_slot (
      .Clk          (Clk),
      .Reset        (Reset),
      .clear        (start),
      .release_use  ((state == ST_ACTIVE) && lock),
      .hold_go      (hold_go),
      .active_shape (cur_shape),
      .hold_shape   (held),
      .hold_used    (hold_used)
   );
`else
   logic unused_hold_req;

   assign unused_hold_req = hold_req;
   assign hold_go         = 1'b0;
   assign held            = SHAPE_NONE;
`endif

   // Spawner FSM with registered outputs; start overrides every state.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= ST_IDLE;
         cur_shape   <= SHAPE_NONE;
         spawn_x     <= 4'd0;
         spawn_y     <= 5'd0;
         piece_req   <= 1'b0;
         spawn_pulse <= 1'b0;
         game_over   <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         piece_req   <= 1'b0;
         spawn_pulse <= 1'b0;
         if (start) begin
            state     <= ST_REQ;
            piece_req <= 1'b1;
            game_over <= 1'b0;
            wait_cnt  <= '0;
         end else begin
            case (state)
               ST_IDLE: state <= ST_IDLE;
               ST_REQ: begin
                  state    <= ST_WAIT;
                  wait_cnt <= '0;
               end
               ST_WAIT: begin
                  if (piece_valid) begin
                     if (shape_legal(piece_in)) begin
                        cur_shape <= shape_t'(piece_in);
                        spawn_x   <= 4'(SPAWN_X);
                        spawn_y   <= 5'(SPAWN_Y);
                        state     <= ST_CHECK;
                     end else begin
                        state     <= ST_REQ;
                        piece_req <= 1'b1;
                     end
                  end else if (wait_cnt == CNT_W'(REQ_TIMEOUT - 1)) begin
                     cur_shape <= SHAPE_I;
                     spawn_x   <= 4'(SPAWN_X);
                     spawn_y   <= 5'(SPAWN_Y);
                     state     <= ST_CHECK;
                  end else begin
                     wait_cnt  <= wait_cnt + 1'b1;
                  end
               end
               ST_CHECK: begin
                  if (occupied) begin
                     game_over   <= 1'b1;
                     state       <= ST_OVER;
                  end else begin
                     spawn_pulse <= 1'b1;
                     state       <= ST_ACTIVE;
                  end
               end
               ST_ACTIVE: begin
                  if (lock) begin
                     state     <= ST_REQ;
                     piece_req <= 1'b1;
                  end else if (hold_go) begin
                     if (held == SHAPE_NONE) begin
                        state     <= ST_REQ;
                        piece_req <= 1'b1;
                     end else begin
                        cur_shape <= held;
                        spawn_x   <= 4'(SPAWN_X);
                        spawn_y   <= 5'(SPAWN_Y);
                        state     <= ST_CHECK;
                     end
                  end
               end
               ST_OVER: state <= ST_OVER;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_piece_spawner.sv
// Testbench for piece_spawner (default build, or with HOLD_PIECE_EN defined).
module tb_piece_spawner;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       start, lock, piece_valid, occupied, hold_req;
   logic [2:0] piece_in;
   logic       piece_req;
   logic [2:0] active_shape;
   logic [3:0] spawn_x;
   logic [4:0] spawn_y;
   logic [1:0] rotation;
   logic       spawn_pulse;
   logic [2:0] hold_shape;
   logic       game_over;

   int checks = 0;
   int errors = 0;

`ifdef HOLD_PIECE_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   // Game-level reference state
   int exp_active = 0;
   int exp_hold   = 0;
   bit exp_used   = 0;
   int exp_over   = 0;

   always #5 Clk = ~Clk;

   piece_spawner dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .start        (start),
      .lock         (lock),
      .piece_valid  (piece_valid),
      .piece_in     (piece_in),
      .occupied     (occupied),
      .hold_req     (hold_req),
      .piece_req    (piece_req),
      .active_shape (active_shape),
      .spawn_x      (spawn_x),
      .spawn_y      (spawn_y),
      .rotation     (rotation),
      .spawn_pulse  (spawn_pulse),
      .hold_shape   (hold_shape),
      .game_over    (game_over)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
      check("req_spawn_exclusive", {31'd0, piece_req & spawn_pulse}, 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req"},    piece_req,    0);
      check({tag, "_active"}, active_shape, 0);
      check({tag, "_sx"},     spawn_x,      0);
      check({tag, "_sy"},     spawn_y,      0);
      check({tag, "_rot"},    rotation,     0);
      check({tag, "_pulse"},  spawn_pulse,  0);
      check({tag, "_hold"},   hold_shape,   0);
      check({tag, "_over"},   game_over,    0);
   endtask

   // Cycles with no start/lock/hold; other inputs are random noise.
   task automatic noise(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         piece_valid = 1'($urandom);
         piece_in    = 3'($urandom);
         occupied    = 1'($urandom);
         tick();
         check({tag, "_noreq"},  piece_req,    0);
         check({tag, "_active"}, active_shape, exp_active);
         check({tag, "_hold"},   hold_shape,   exp_hold);
         check({tag, "_over"},   game_over,    exp_over);
      end
      piece_valid = 0;
      occupied    = 0;
   endtask

   // Current cycle is the WAIT->CHECK latch result; resolve the spawn check.
   task automatic spawn_check(input bit occ, input string tag);
      occupied = occ;
      tick();
      occupied = 1'($urandom);
      if (occ) begin
         exp_over = 1;
         check({tag, "_over"},  game_over,   1);
         check({tag, "_pulse"}, spawn_pulse, 0);
      end else begin
         check({tag, "_over"},  game_over,   0);
         check({tag, "_pulse"}, spawn_pulse, 1);
         tick();
         check({tag, "_pulse1"}, spawn_pulse, 0);
      end
      occupied = 0;
   endtask

   // Called in the cycle where piece_req is high. Answers with shape after dly WAIT cycles.
   task automatic serve(input int shape, input int dly, input bit occ, input string tag);
      check({tag, "_reqhi"}, piece_req, 1);
      tick();
      check({tag, "_reqlo"}, piece_req, 0);
      for (int i = 0; i < dly; i++) begin
         occupied = 1'($urandom);
         tick();
         check({tag, "_waitreq"}, piece_req, 0);
      end
      piece_valid = 1;
      piece_in    = 3'(shape);
      tick();
      piece_valid = 0;
      piece_in    = 3'($urandom);
      if (shape == 0) begin
         check({tag, "_rereq"}, piece_req, 1);
      end else begin
         exp_active = shape;
         check({tag, "_active"}, active_shape, exp_active);
         check({tag, "_sx"},     spawn_x,      4);
         check({tag, "_sy"},     spawn_y,      0);
         check({tag, "_rot"},    rotation,     0);
         check({tag, "_pulse0"}, spawn_pulse,  0);
         spawn_check(occ, tag);
      end
   endtask

   task automatic do_lock(input string tag);
      lock = 1;
      tick();
      lock = 0;
      exp_used = 0;
      check({tag, "_req"}, piece_req, 1);
   endtask

   // Returns 1 if the spawner went back to requesting a piece.
   task automatic do_hold(input string tag, output bit went_req);
      int tmp;
      hold_req = 1;
      tick();
      hold_req = 0;
      went_req = 0;
      if (HOLD_EN && !exp_used) begin
         exp_used = 1;
         if (exp_hold == 0) begin
            exp_hold = exp_active;
            went_req = 1;
            check({tag, "_req"},  piece_req,  1);
            check({tag, "_hold"}, hold_shape, exp_hold);
         end else begin
            tmp        = exp_hold;
            exp_hold   = exp_active;
            exp_active = tmp;
            check({tag, "_req"},    piece_req,    0);
            check({tag, "_active"}, active_shape, exp_active);
            check({tag, "_hold"},   hold_shape,   exp_hold);
            check({tag, "_sx"},     spawn_x,      4);
            spawn_check(0, {tag, "_swap"});
         end
      end else begin
         check({tag, "_ign_req"},    piece_req,    0);
         check({tag, "_ign_active"}, active_shape, exp_active);
         check({tag, "_ign_hold"},   hold_shape,   exp_hold);
         tick();
         check({tag, "_ign_req1"},   piece_req,    0);
      end
   endtask

   initial begin
      bit wr;
      int prev;
      Reset = 1; start = 0; lock = 0; piece_valid = 0; piece_in = 0;
      occupied = 0; hold_req = 0;
      #12;
      check_all_zero("reset");
      @(negedge Clk);
      Reset = 0;

      // IDLE ignores everything but start
      for (int i = 0; i < 6; i++) begin
         lock = 1'($urandom); hold_req = 1'($urandom);
         piece_valid = 1'($urandom); piece_in = 3'($urandom);
         tick();
         check("idle_noreq",  piece_req,    0);
         check("idle_active", active_shape, 0);
      end
      lock = 0; hold_req = 0; piece_valid = 0;

      // First piece: shape 5 after 3 cycles
      start = 1; tick(); start = 0;
      check("start_req", piece_req, 1);
      serve(5, 3, 0, "first");
      noise(4, "act1");

      // Lock, illegal answer, then shape 3
      do_lock("lock1");
      serve(0, $urandom_range(0, 5), 0, "illegal");
      serve(3, $urandom_range(0, 5), 0, "three");

      // Hold sequence: active 2, hold, active 6, ignored hold, lock, active 4, swap
      do_lock("lock2");
      serve(2, $urandom_range(0, 4), 0, "two");
      do_hold("hold1", wr);
      if (wr) serve(6, $urandom_range(0, 4), 0, "six");
      do_hold("hold2", wr);
      if (wr) serve(6, 1, 0, "six_b");
      do_lock("lock3");
      serve(4, $urandom_range(0, 4), 0, "four");
      do_hold("hold3", wr);
      if (wr) serve(7, 1, 0, "seven");
      noise(3, "act2");

      // lock and hold_req together: lock wins
      lock = 1; hold_req = 1; tick(); lock = 0; hold_req = 0;
      exp_used = 0;
      check("lockhold_req",  piece_req,  1);
      check("lockhold_hold", hold_shape, exp_hold);
      serve(6, 2, 0, "after_lh");

      // Timeout: no piece_valid for REQ_TIMEOUT cycles gives shape 1
      do_lock("lock_to");
      prev = exp_active;
      tick();
      for (int i = 0; i < 30; i++) begin
         occupied = 1'($urandom);
         tick();
      end
      occupied = 0;
      check("to_before", active_shape, prev);
      check("to_noreq",  piece_req,    0);
      tick();
      exp_active = 1;
      check("to_active", active_shape, 1);
      check("to_sx",     spawn_x,      4);
      spawn_check(0, "to");

      // start while ACTIVE restarts with hold cleared
      start = 1; tick(); start = 0;
      exp_hold = 0; exp_used = 0;
      check("restart_req",  piece_req,  1);
      check("restart_hold", hold_shape, 0);
      serve($urandom_range(1, 7), $urandom_range(0, 6), 0, "restart");

      // Random play
      for (int g = 0; g < 20; g++) begin
         case ($urandom_range(0, 2))
            0: begin
               do_lock("rnd_lock");
               if ($urandom_range(0, 3) == 0) serve(0, $urandom_range(0, 8), 0, "rnd_bad");
               serve($urandom_range(1, 7), $urandom_range(0, 20), 0, "rnd_piece");
            end
            1: begin
               do_hold("rnd_hold", wr);
               if (wr) serve($urandom_range(1, 7), $urandom_range(0, 10), 0, "rnd_hpiece");
            end
            default: noise($urandom_range(1, 4), "rnd_idle");
         endcase
      end

      // Spawn collision -> game over, held for 100 cycles
      do_lock("lock_go");
      serve($urandom_range(1, 7), $urandom_range(0, 5), 1, "collide");
      for (int i = 0; i < 100; i++) begin
         lock = 1'($urandom); hold_req = 1'($urandom);
         piece_valid = 1'($urandom); piece_in = 3'($urandom);
         occupied = 1'($urandom);
         tick();
         check("over_level",  game_over,    1);
         check("over_active", active_shape, exp_active);
         check("over_noreq",  piece_req,    0);
         check("over_hold",   hold_shape,   exp_hold);
      end
      lock = 0; hold_req = 0; piece_valid = 0; occupied = 0;
      start = 1; tick(); start = 0;
      exp_over = 0; exp_hold = 0; exp_used = 0;
      check("over_start_go",   game_over,  0);
      check("over_start_req",  piece_req,  1);
      check("over_start_hold", hold_shape, 0);

      // Reset in the middle of WAIT
      tick();
      tick(); tick();
      @(posedge Clk);
      #3 Reset = 1;
      #1;
      exp_active = 0; exp_hold = 0; exp_used = 0; exp_over = 0;
      check_all_zero("wait_reset");
      @(negedge Clk);
      Reset = 0;
      for (int i = 0; i < 20; i++) begin
         lock = 1'($urandom); hold_req = 1'($urandom);
         piece_valid = 1'($urandom); piece_in = 3'($urandom);
         tick();
         check("post_reset_noreq",  piece_req,    0);
         check("post_reset_active", active_shape, 0);
      end
      lock = 0; hold_req = 0; piece_valid = 0;
      start = 1; tick(); start = 0;
      check("post_reset_start", piece_req, 1);
      serve(7, 2, 0, "post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/piece_spawner.md
PIECE_SPAWNER -- requirements
Module: piece_spawner

Interface
REQ-001 Parameter: SPAWN_X, 4, spawn column of the active piece's origin.
REQ-002 Parameter: SPAWN_Y, 0, spawn row of the active piece's origin.
REQ-003 Parameter: REQ_TIMEOUT, 31, maximum cycles in WAIT before falling back to the default shape.
REQ-004 Port: Clk  in  1  system clock.
REQ-005 Port: Reset  in  1  asynchronous, active-high reset.
REQ-006 Port: start  in  1  single-cycle pulse that begins or restarts a game.
REQ-007 Port: lock  in  1  single-cycle pulse when the active piece has locked into the board.
REQ-008 Port: piece_valid  in  1  the generator's piece_in is valid this cycle.
REQ-009 Port: piece_in  in  3  shape code from the generator; 1..7 legal, 0 illegal.
REQ-010 Port: occupied  in  1  board reports a collision at the spawn footprint of active_shape.
REQ-011 Port: hold_req  in  1  single-cycle pulse from the player's hold button.
REQ-012 Port: piece_req  out  1  single-cycle pulse requesting the next shape.
REQ-013 Port: active_shape  out  3  shape currently in play; 0 = none.
REQ-014 Port: spawn_x / spawn_y  out  4 / 5  origin of the active piece at spawn.
REQ-015 Port: rotation  out  2  spawn rotation; always 0 at spawn.
REQ-016 Port: spawn_pulse  out  1  single-cycle pulse when a new piece becomes active.
REQ-017 Port: hold_shape  out  3  shape held; 0 = empty.
REQ-018 Port: game_over  out  1  level signal; spawn collided.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, CHECK, ACTIVE, OVER.
REQ-020 IDLE SHALL go to REQ on start; all other inputs are ignored in IDLE.
REQ-021 REQ SHALL assert piece_req for exactly one cycle, then go to WAIT.
REQ-022 WAIT, on piece_valid with piece_in in 1..7, SHALL latch active_shape, load spawn_x=SPAWN_X, spawn_y=SPAWN_Y, rotation=0, and go to CHECK.
REQ-023 WAIT, on piece_valid with piece_in=0, SHALL return to REQ (re-request).
REQ-024 WAIT SHALL count cycles; after REQ_TIMEOUT cycles without a valid piece, it SHALL latch shape 1 and go to CHECK.
REQ-025 CHECK SHALL sample occupied one cycle after the shape is latched.
REQ-026 CHECK with occupied=0 SHALL pulse spawn_pulse and go to ACTIVE.
REQ-027 CHECK with occupied=1 SHALL set game_over=1 and go to OVER.
REQ-028 ACTIVE SHALL go to REQ on lock, and SHALL clear the hold_used flag.
REQ-029 If lock and hold_req arrive in the same cycle, lock SHALL win and hold_req is dropped.
REQ-030 OVER SHALL hold game_over=1 and active_shape unchanged until start.
REQ-031 start in OVER SHALL clear game_over, hold_shape and hold_used, then go to REQ.
REQ-032 start in any state other than IDLE or OVER SHALL restart the game at REQ with hold cleared.
REQ-033 spawn_pulse and piece_req SHALL never be asserted in the same cycle.

Reset
REQ-034 On Reset, the block SHALL enter IDLE.
REQ-035 On Reset, all outputs, hold_used and the timeout counter SHALL clear to 0.
REQ-036 Reset asserted mid-WAIT SHALL abandon the pending request with no further piece_req.

Configuration
REQ-037 With HOLD_PIECE_EN defined, hold_req in ACTIVE with hold_used=0 SHALL set hold_used=1.
REQ-038 Hold, slot empty: store active_shape into hold_shape and go to REQ.
REQ-039 Hold, slot full: swap active_shape and hold_shape, reload the spawn position, and go to CHECK.
REQ-040 With hold_used=1, hold_req SHALL be ignored.
REQ-041 Without HOLD_PIECE_EN, hold_req SHALL be ignored, hold_shape SHALL be tied to 0, and the hold logic SHALL be absent.

Structure
REQ-042 Shared package tetris_pkg SHALL hold shape_t (3-bit, NONE=0, shapes 1..7), spawner_state_t, and the board width/height constants.
REQ-043 The hold slot and swap logic SHALL live in sub-module hold_slot, instantiated only under HOLD_PIECE_EN.

Verification
REQ-044 Reset, then start; answer piece_req after 3 cycles with piece_in=5, occupied=0 -> active_shape=5, spawn_x=4, spawn_y=0, spawn_pulse 1 cycle.
REQ-045 In ACTIVE, lock pulse -> piece_req pulse on the next cycle; answer piece_in=0 -> a second piece_req; answer 3 -> active_shape=3.
REQ-046 No piece_valid for 31 cycles after piece_req -> active_shape=1, followed by spawn_pulse.
REQ-047 occupied=1 in CHECK -> game_over=1 held for 100 cycles; start -> game_over=0 and a piece_req pulse.
REQ-048 HOLD_PIECE_EN defined, active 2 -> hold_req gives hold_shape=2 and piece_req.
REQ-049 Continue REQ-048 with active 6 -> a second hold_req is ignored; after lock and a new piece 4, hold_req gives active_shape=2 and hold_shape=4.
REQ-050 Reset asserted in WAIT -> all outputs 0, state IDLE, and no piece_req until start.
